stroke_rasterizer: RTL

//  Turns the PS/2 mouse cursor position and buttons into framebuffer writes for the
//  640x480 1-bit drawing canvas (dual-port block RAM, port A). Consecutive cursor

---
 rtl/stroke_pkg.sv | 33 +++
 rtl/line_stepper.sv | 92 +++++++++
 rtl/stroke_rasterizer.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/stroke_pkg.sv
// Shared constants, state encoding and address helper for the stroke rasterizer.
package stroke_pkg;

    localparam int H_RES     = 640;
    localparam int V_RES     = 480;
    localparam int FB_DEPTH  = H_RES * V_RES;
    localparam int COORD_W   = 10;
    localparam int FB_ADDR_W = 19;
    localparam int DELTA_W   = 12;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        INIT  = 2'd1,
        STEP  = 2'd2,
        CLEAR = 2'd3
    } state_t;

    localparam logic PEN_DRAW  = 1'b1;
    localparam logic PEN_ERASE = 1'b0;

    typedef logic [COORD_W-1:0] coord_t;

    typedef struct packed {
        coord_t x;
        coord_t y;
    } point_t;

    // 640*y built from two shifts so no multiplier is inferred.
    function automatic logic [FB_ADDR_W-1:0] pixel_addr(input coord_t x, input coord_t y);
        return FB_ADDR_W'(x) + (FB_ADDR_W'(y) << 9) + (FB_ADDR_W'(y) << 7);
    endfunction

endpackage

// File: rtl/line_stepper.sv
// Bresenham core: emits one pixel per cycle, the first one in the same cycle as load,
// so the caller can register it straight into the framebuffer write port.
module line_stepper
    import stroke_pkg::*;
(
    input  logic   clk,
    input  logic   rst,
    input  logic   load,
    input  coord_t x0,
    input  coord_t y0,
    input  coord_t x1,
    input  coord_t y1,
    output coord_t cur_x,
    output coord_t cur_y,
    output logic   pixel_valid,
    output logic   done
);

    typedef logic signed [DELTA_W-1:0] delta_t;

    coord_t x_reg, y_reg, tx_reg, ty_reg;
    delta_t dx_reg, dy_reg, err_reg;
    logic   sx_reg, sy_reg, active_reg;

    delta_t ld_dx, ld_dy, c_dx, c_dy, c_err, e2, err_next;
    coord_t tx, ty, x_next, y_next;
    logic   sx, sy, at_end;

    always_comb begin
        ld_dx = $signed({2'b00, x1}) - $signed({2'b00, x0});
        ld_dy = $signed({2'b00, y1}) - $signed({2'b00, y0});

        // On load the working values come straight from the inputs, otherwise from state.
        sx    = load ? ld_dx[DELTA_W-1] : sx_reg;
        sy    = load ? ld_dy[DELTA_W-1] : sy_reg;
        c_dx  = load ? (ld_dx[DELTA_W-1] ? -ld_dx : ld_dx) : dx_reg;
        c_dy  = load ? (ld_dy[DELTA_W-1] ? -ld_dy : ld_dy) : dy_reg;
        c_err = load ? (c_dx - c_dy) : err_reg;
        cur_x = load ? x0 : x_reg;
        cur_y = load ? y0 : y_reg;
        tx    = load ? x1 : tx_reg;
        ty    = load ? y1 : ty_reg;

        at_end   = (cur_x == tx) && (cur_y == ty);
        e2       = c_err <<< 1;
        err_next = c_err;
        x_next   = cur_x;
        y_next   = cur_y;
        if (e2 > -c_dy) begin
            err_next = err_next - c_dy;
            x_next   = sx ? cur_x - COORD_W'(1) : cur_x + COORD_W'(1);
        end
        if (e2 < c_dx) begin
            err_next = err_next + c_dx;
            y_next   = sy ? cur_y - COORD_W'(1) : cur_y + COORD_W'(1);
        end

        pixel_valid = load | active_reg;
        done        = pixel_valid & at_end;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            active_reg <= 1'b0;
            x_reg      <= '0;
            y_reg      <= '0;
            tx_reg     <= '0;
            ty_reg     <= '0;
            dx_reg     <= '0;
            dy_reg     <= '0;
            err_reg    <= '0;
            sx_reg     <= 1'b0;
            sy_reg     <= 1'b0;
        end else begin
            if (pixel_valid) begin
                x_reg      <= x_next;
                y_reg      <= y_next;
                err_reg    <= err_next;
                active_reg <= !at_end;
            end
            if (load) begin
                tx_reg <= x1;
                ty_reg <= y1;
                dx_reg <= c_dx;
                dy_reg <= c_dy;
                sx_reg <= sx;
                sy_reg <= sy;
            end
        end
    end

endmodule

// File: rtl/stroke_rasterizer.sv
// Mouse-driven pen: joins cursor positions with Bresenham lines into the 1-bit canvas.
// Define CLEAR_SCREEN_EN to let a middle-button press wipe the whole canvas.
module stroke_rasterizer
    import stroke_pkg::*;
#(
    parameter int H_RES  = 640,
    parameter int V_RES  = 480,
    parameter int ADDR_W = 19
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [9:0]          mouse_x,
    input  logic [9:0]          mouse_y,
    input  logic                mouse_left,
    input  logic                mouse_right,
    input  logic                mouse_middle,
    output logic [ADDR_W-1:0]   write_addr,
    output logic                write_enable,
    output logic                write_data,
    output logic                busy
);

    state_t            state_reg, state_next;
    point_t            last_reg, last_next;
    point_t            pend_start_reg, pend_start_next, pend_end_reg, pend_end_next;
    point_t            start_reg, start_next, end_reg, end_next;
    logic              pend_valid_reg, pend_valid_next;
    logic              colour_reg, colour_next;
    logic              last_pix_reg, last_pix_next;
    logic              we_reg, we_next, data_reg, data_next;
    logic [ADDR_W-1:0] addr_reg, addr_next;
    logic              pen_prev_reg;

    point_t pos, req_start;
    logic   pen_down, rise, req, load;
    coord_t step_x, step_y;
    logic   step_valid, step_done;

`ifdef CLEAR_SCREEN_EN
    logic mid_prev_reg;
    logic mid_rise;
    assign mid_rise = mouse_middle & ~mid_prev_reg;
`else
    logic unused_middle;
    assign unused_middle = mouse_middle;
`endif

    always_comb begin
        pos.x     = (mouse_x > COORD_W'(H_RES - 1)) ? COORD_W'(H_RES - 1) : mouse_x;
        pos.y     = (mouse_y > COORD_W'(V_RES - 1)) ? COORD_W'(V_RES - 1) : mouse_y;
        pen_down  = mouse_left | mouse_right;
        rise      = pen_down & ~pen_prev_reg;
        req       = pen_down & (rise | (pos != last_reg));
        req_start = rise ? pos : last_reg;
    end

    line_stepper u_stepper (
        .clk         (clk),
        .rst         (rst),
        .load        (load),
        .x0          (start_reg.x),
        .y0          (start_reg.y),
        .x1          (end_reg.x),
        .y1          (end_reg.y),
        .cur_x       (step_x),
        .cur_y       (step_y),
        .pixel_valid (step_valid),
        .done        (step_done)
    );

    always_comb begin
        state_next      = state_reg;
        last_next       = last_reg;
        pend_valid_next = pend_valid_reg;
        pend_start_next = pend_start_reg;
        pend_end_next   = pend_end_reg;
        start_next      = start_reg;
        end_next        = end_reg;
        colour_next     = colour_reg;
        last_pix_next   = last_pix_reg;
        we_next         = 1'b0;
        addr_next       = addr_reg;
        data_next       = data_reg;
        load            = 1'b0;

        case (state_reg)
            IDLE: begin
`ifdef CLEAR_SCREEN_EN
                if (mid_rise) begin
                    state_next = CLEAR;
                    we_next    = 1'b1;
                    addr_next  = '0;
                    data_next  = PEN_ERASE;
                end else
`endif
                if (req) begin
                    state_next      = INIT;
                    start_next      = req_start;
                    end_next        = pos;
                    last_next       = pos;
                    colour_next     = mouse_left ? PEN_DRAW : PEN_ERASE;
                    pend_valid_next = 1'b0;
                end
            end

            INIT, STEP: begin
                // Newest request overwrites the pending one but keeps its start so
                // skipped intermediate positions leave no gap.
                if (!pen_down) begin
                    pend_valid_next = 1'b0;
                end else if (req) begin
                    pend_valid_next = 1'b1;
                    pend_start_next = rise ? pos : (pend_valid_reg ? pend_start_reg : last_reg);
                    pend_end_next   = pos;
                    last_next       = pos;
                end

                if (state_reg == INIT) begin
                    load          = 1'b1;
                    state_next    = STEP;
                    we_next       = step_valid;
                    addr_next     = ADDR_W'(pixel_addr(step_x, step_y));
                    data_next     = colour_reg;
                    last_pix_next = step_done;
                end else if (last_pix_reg) begin
                    last_pix_next = 1'b0;
                    if (pend_valid_next) begin
                        state_next      = INIT;
                        start_next      = pend_start_next;
                        end_next        = pend_end_next;
                        colour_next     = mouse_left ? PEN_DRAW : PEN_ERASE;
                        pend_valid_next = 1'b0;
                    end else begin
                        state_next = IDLE;
                    end
                end else begin
                    we_next       = step_valid;
                    addr_next     = ADDR_W'(pixel_addr(step_x, step_y));
                    last_pix_next = step_done;
                end
            end

`ifdef CLEAR_SCREEN_EN
            CLEAR: begin
                pend_valid_next = 1'b0;
                we_next         = 1'b1;
                data_next       = PEN_ERASE;
                if (addr_reg == ADDR_W'(H_RES * V_RES - 1)) begin
                    state_next = IDLE;
                    we_next    = 1'b0;
                    last_next  = '0;
                end else begin
                    addr_next = addr_reg + 1'b1;
                end
            end
`endif

            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg      <= IDLE;
            last_reg       <= '0;
            pend_valid_reg <= 1'b0;
            pend_start_reg <= '0;
            pend_end_reg   <= '0;
            start_reg      <= '0;
            end_reg        <= '0;
            colour_reg     <= PEN_ERASE;
            last_pix_reg   <= 1'b0;
            we_reg         <= 1'b0;
            addr_reg       <= '0;
            data_reg       <= 1'b0;
            pen_prev_reg   <= 1'b0;
`ifdef CLEAR_SCREEN_EN
            mid_prev_reg   <= 1'b0;
`endif
        end else begin
            state_reg      <= state_next;
            last_reg       <= last_next;
            pend_valid_reg <= pend_valid_next;
            pend_start_reg <= pend_start_next;
            pend_end_reg   <= pend_end_next;
            start_reg      <= start_next;
            end_reg        <= end_next;
            colour_reg     <= colour_next;
            last_pix_reg   <= last_pix_next;
            we_reg         <= we_next;
            addr_reg       <= addr_next;
            data_reg       <= data_next;
            pen_prev_reg   <= pen_down;
`ifdef CLEAR_SCREEN_EN
            mid_prev_reg   <= mouse_middle;
`endif
        end
    end

    assign write_enable = we_reg;
    assign write_addr   = addr_reg;
    assign write_data   = data_reg;
    assign busy         = (state_reg != IDLE);

endmodule
